// File: rtl/prog_mem_pkg.sv
// Shared definitions for the program memory: default geometry and loader FSM states.
package prog_mem_pkg;

   localparam int DEF_DATA_WIDTH = 24;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_DEPTH      = 256;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_COMMIT  = 2'd2
   } load_state_e;

endpackage

// File: rtl/prog_mem_if.sv
// Fetch port plus byte-loader handshake of the program memory, grouped as one bus.
interface prog_mem_if
   import prog_mem_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  addr_error;
   logic                  load_start;
   logic [ADDR_WIDTH-1:0] load_addr;
   logic                  load_end;
   logic                  load_valid;
   logic [7:0]            load_byte;
   logic                  load_ready;
   logic                  load_busy;
   logic                  load_error;
   logic                  parity_error;

   modport master (
      output address, load_start, load_addr, load_end, load_valid, load_byte,
      input  data_out, addr_error, load_ready, load_busy, load_error, parity_error
   );

   modport slave (
      input  address, load_start, load_addr, load_end, load_valid, load_byte,
      output data_out, addr_error, load_ready, load_busy, load_error, parity_error
   );

endinterface

// File: rtl/prog_mem_loader.sv
// Byte assembler and load-session FSM: packs MSB-first bytes into words and
// emits one write per completed word.
module prog_mem_loader
   import prog_mem_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DEPTH      = DEF_DEPTH
) (
   input  logic                  clock,
   input  logic                  reset_s2,
   input  logic                  load_start,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic                  load_end,
   input  logic                  load_valid,
   input  logic [7:0]            load_byte,
   output logic                  load_ready,
   output logic                  load_busy,
   output logic                  load_error,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data
);

   localparam int                  BYTES    = DATA_WIDTH / 8;
   localparam int                  CNT_W    = 3;
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(BYTES - 1);
   localparam logic [ADDR_WIDTH:0] DEPTH_X  = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(DEPTH - 1);

   load_state_e           state_q, state_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic                  err_q, err_d;
   logic                  ready_q, ready_d;
   logic                  busy_q, busy_d;

   // NOTE: every _d gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      word_d   = word_q;
      err_d    = err_q;
      if (load_start) begin
         // A restart wins over load_end and any byte offered in the same cycle.
         cnt_d = '0;
         if ({1'b0, load_addr} < DEPTH_X) begin
            wr_ptr_d = load_addr;
            err_d    = 1'b0;
            state_d  = ST_COLLECT;
         end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
         end
      end else begin
         unique case (state_q)
            ST_COLLECT: begin
               if (load_end) begin
                  err_d   = err_q | (cnt_q != '0);
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end else if (load_valid) begin
                  word_d = (word_q << 8) | DATA_WIDTH'(load_byte);
                  if (cnt_q == CNT_LAST) begin
                     cnt_d   = '0;
                     state_d = ST_COMMIT;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            ST_COMMIT: begin
               // The last word stops the session rather than wrapping to address 0.
               if (wr_ptr_q == LAST) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  state_d  = ST_COLLECT;
               end
            end
            default: ;
         endcase
      end
      ready_d = (state_d == ST_COLLECT);
      busy_d  = (state_d != ST_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset_s2) begin
      if (reset_s2) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         word_q   <= '0;
         err_q    <= 1'b0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         word_q   <= word_d;
         err_q    <= err_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
      end
   end

   assign load_ready = ready_q;
   assign load_busy  = busy_q;
   assign load_error = err_q;
   assign wr_en      = (state_q == ST_COMMIT);
   assign wr_addr    = wr_ptr_q;
   assign wr_data    = word_q;

endmodule

// File: rtl/prog_mem.sv
// Program memory with registered fetch port and in-system byte loader.
// Define PROG_MEM_PARITY_EN to store and check an even-parity bit per word.
module prog_mem
   import prog_mem_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DEPTH      = DEF_DEPTH
) (
   input logic         clock,
   input logic         reset_s2,
   prog_mem_if.slave   bus
);

   localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);

   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [IDX_W-1:0]      rd_idx, wr_idx;
   logic                  in_range;

   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  addr_err_q, addr_err_d;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   prog_mem_loader #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_loader (
      .clock      (clock),
      .reset_s2   (reset_s2),
      .load_start (bus.load_start),
      .load_addr  (bus.load_addr),
      .load_end   (bus.load_end),
      .load_valid (bus.load_valid),
      .load_byte  (bus.load_byte),
      .load_ready (bus.load_ready),
      .load_busy  (bus.load_busy),
      .load_error (bus.load_error),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data)
   );

   assign rd_idx   = bus.address[IDX_W-1:0];
   assign wr_idx   = wr_addr[IDX_W-1:0];
   assign in_range = ({1'b0, bus.address} < DEPTH_X);

   // NOTE: the array has no reset branch; program contents must survive a reset.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   // The read samples pre-edge contents, so a same-cycle commit returns the old word.
   always_comb begin
      data_d     = data_q;
      addr_err_d = 1'b0;
      if (in_range) begin
         data_d = mem[rd_idx];
      end else begin
         addr_err_d = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset_s2) begin
      if (reset_s2) begin
         data_q     <= '0;
         addr_err_q <= 1'b0;
      end else begin
         data_q     <= data_d;
         addr_err_q <= addr_err_d;
      end
   end

   assign bus.data_out   = data_q;
   assign bus.addr_error = addr_err_q;

`ifdef PROG_MEM_PARITY_EN
   logic par_mem [DEPTH];
   logic par_err_q, par_err_d;

   always_ff @(posedge clock) begin
      if (wr_en) begin
         par_mem[wr_idx] <= ^wr_data;
      end
   end

   always_comb begin
      par_err_d = 1'b0;
      if (in_range) begin
         par_err_d = (^mem[rd_idx]) ^ par_mem[rd_idx];
      end
   end

   always_ff @(posedge clock or posedge reset_s2) begin
      if (reset_s2) begin
         par_err_q <= 1'b0;
      end else begin
         par_err_q <= par_err_d;
      end
   end

   assign bus.parity_error = par_err_q;
`else
   assign bus.parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem (DEPTH=27); the parity sequence runs when
// PROG_MEM_PARITY_EN is defined.
module tb_prog_mem;

   logic clock    = 1'b0;
   logic reset_s2 = 1'b1;

   always #5 clock = ~clock;

   prog_mem_if #(.DATA_WIDTH(24), .ADDR_WIDTH(8)) bus ();

   prog_mem #(
      .DATA_WIDTH (24),
      .ADDR_WIDTH (8),
      .DEPTH      (27)
   ) dut (
      .clock    (clock),
      .reset_s2 (reset_s2),
      .bus      (bus)
   );

   int n_run  = 0;
   int n_fail = 0;

   typedef struct {
      logic        start;
      logic [7:0]  laddr;
      logic        lend;
      logic        lvalid;
      logic [7:0]  lbyte;
      logic [7:0]  addr;
      logic        chk_data;
      logic [23:0] exp_data;
      logic        exp_aerr;
      logic        exp_ready;
      logic        exp_busy;
      logic        exp_err;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Drive one cycle of inputs at a falling edge and advance to the next falling edge.
   task automatic cyc(input logic st, input logic [7:0] la, input logic en,
                      input logic vl, input logic [7:0] b, input logic [7:0] a);
      bus.load_start = st;
      bus.load_addr  = la;
      bus.load_end   = en;
      bus.load_valid = vl;
      bus.load_byte  = b;
      bus.address    = a;
      @(negedge clock);
   endtask

   task automatic chk_ctl(input string tag, input logic r, input logic b, input logic e);
      check({tag, " load_ready"}, 32'(bus.load_ready), 32'(r));
      check({tag, " load_busy"},  32'(bus.load_busy),  32'(b));
      check({tag, " load_error"}, 32'(bus.load_error), 32'(e));
   endtask

   initial begin
      bus.load_start = 1'b0;
      bus.load_addr  = '0;
      bus.load_end   = 1'b0;
      bus.load_valid = 1'b0;
      bus.load_byte  = '0;
      bus.address    = '0;

      // Reset state
      repeat (2) @(negedge clock);
      check("rst data_out", 32'(bus.data_out), 32'h0);
      check("rst addr_error", 32'(bus.addr_error), 32'h0);
      check("rst parity_error", 32'(bus.parity_error), 32'h0);
      chk_ctl("rst", 1'b0, 1'b0, 1'b0);
      reset_s2 = 1'b0;
      @(negedge clock);

      // Two-word session at 0x10, then fetches including an out-of-range one
      //            st    laddr  end   vld   byte   addr   chk   data        aerr  rdy   busy  err
      vecs[0]  = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 24'h0,      1'b0, 1'b1, 1'b1, 1'b0};
      vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h0A, 8'h00, 1'b0, 24'h0,      1'b0, 1'b1, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 24'h0,      1'b0, 1'b1, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h05, 8'h00, 1'b0, 24'h0,      1'b0, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hEE, 8'h00, 1'b0, 24'h0,      1'b0, 1'b1, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0, 24'h0,      1'b0, 1'b1, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 8'h00, 1'b0, 24'h0,      1'b0, 1'b1, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 8'h00, 1'b0, 24'h0,      1'b0, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h10, 1'b1, 24'h0A1005, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h11, 1'b1, 24'h010203, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h1B, 1'b1, 24'h010203, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h10, 1'b1, 24'h0A1005, 1'b0, 1'b0, 1'b0, 1'b0};

      for (int i = 0; i < 12; i++) begin
         cyc(vecs[i].start, vecs[i].laddr, vecs[i].lend, vecs[i].lvalid, vecs[i].lbyte, vecs[i].addr);
         chk_ctl($sformatf("v%0d", i), vecs[i].exp_ready, vecs[i].exp_busy, vecs[i].exp_err);
         check($sformatf("v%0d addr_error", i), 32'(bus.addr_error), 32'(vecs[i].exp_aerr));
         if (vecs[i].chk_data) begin
            check($sformatf("v%0d data_out", i), 32'(bus.data_out), 32'(vecs[i].exp_data));
         end
      end

      // Known word at 0x00, then a session at DEPTH-1 that must stop without wrapping
      cyc(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 8'h00);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 8'h00);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 8'h00);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00);
      chk_ctl("w0 end", 1'b0, 1'b0, 1'b0);

      cyc(1'b1, 8'h1A, 1'b0, 1'b0, 8'h00, 8'h00);
      chk_ctl("last start", 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'hAA, 8'h00);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'hBB, 8'h00);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'hCC, 8'h00);
      chk_ctl("last full", 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'hDD, 8'h00);
      chk_ctl("last commit", 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'hEE, 8'h00);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 8'h1A);
      chk_ctl("last idle", 1'b0, 1'b0, 1'b1);
      check("last word", 32'(bus.data_out), 32'hAABBCC);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      check("no wrap mem0", 32'(bus.data_out), 32'h112233);

      // Out-of-range fetch holds data_out and pulses addr_error once
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h1B);
      check("oor data hold", 32'(bus.data_out), 32'h112233);
      check("oor addr_error", 32'(bus.addr_error), 32'h1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      check("oor pulse end", 32'(bus.addr_error), 32'h0);

      // Out-of-range load_addr, then a partial word abandoned by load_end
      cyc(1'b1, 8'h1B, 1'b0, 1'b0, 8'h00, 8'h00);
      chk_ctl("bad start", 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00);
      chk_ctl("restart clr", 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 8'h00);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'h88, 8'h00);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00);
      chk_ctl("partial end", 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h11);
      check("partial unwritten", 32'(bus.data_out), 32'h010203);
      cyc(1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 8'h00);
      chk_ctl("next start clr", 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00);
      chk_ctl("empty end", 1'b0, 1'b0, 1'b0);

      // Restart priority, load_end ignored in COMMIT, old word on same-cycle fetch
      cyc(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'h99, 8'h00);
      cyc(1'b1, 8'h10, 1'b1, 1'b1, 8'h55, 8'h00);
      chk_ctl("restart prio", 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'h44, 8'h00);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 8'h00);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'h66, 8'h00);
      cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'h77, 8'h10);
      chk_ctl("end in commit", 1'b1, 1'b1, 1'b0);
      check("same-cycle old", 32'(bus.data_out), 32'h0A1005);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h10);
      chk_ctl("rewrite end", 1'b0, 1'b0, 1'b0);
      check("rewrite new", 32'(bus.data_out), 32'h445566);
      check("parity quiet", 32'(bus.parity_error), 32'h0);

      // Asynchronous reset in the middle of a session and a fetch
      cyc(1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 8'h10);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'h12, 8'h10);
      chk_ctl("pre-reset", 1'b1, 1'b1, 1'b0);
      #2 reset_s2 = 1'b1;
      #1;
      check("async rst data_out", 32'(bus.data_out), 32'h0);
      chk_ctl("async rst", 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      reset_s2 = 1'b0;
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h10);
      check("mem kept", 32'(bus.data_out), 32'h445566);
      chk_ctl("post rst", 1'b0, 1'b0, 1'b0);

`ifdef PROG_MEM_PARITY_EN
      dut.mem[16][0] = ~dut.mem[16][0];
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h10);
      check("flip data", 32'(bus.data_out), 32'h445567);
      check("parity pulse", 32'(bus.parity_error), 32'h1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h11);
      check("parity clear", 32'(bus.parity_error), 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 Parameter DATA_WIDTH, 24, instruction word width in bits (multiple of 8, 8..32) SHALL be supported.
REQ-002 Parameter ADDR_WIDTH, 8, address width in bits SHALL be supported.
REQ-003 Parameter DEPTH, 256, number of words; 1..2^ADDR_WIDTH SHALL be supported.
REQ-004 clock  in  1  system clock; all state SHALL be updated on its rising edge.
REQ-005 reset_s2  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-006 address  in  ADDR_WIDTH  CPU fetch address.
REQ-007 data_out  out  DATA_WIDTH  registered fetched word.
REQ-008 addr_error  out  1  one-cycle pulse when a fetch address is >= DEPTH.
REQ-009 load_start  in  1  single-cycle strobe that opens a load session at load_addr.
REQ-010 load_addr  in  ADDR_WIDTH  first word address of the load session.
REQ-011 load_end  in  1  single-cycle strobe that closes the load session.
REQ-012 load_valid / load_byte  in  1 / 8  byte offer from the loader.
REQ-013 load_ready  out  1  high when a byte is accepted this cycle.
REQ-014 load_busy  out  1  high while a load session is open.
REQ-015 load_error  out  1  sticky error flag, cleared by the next load_start.
REQ-016 parity_error  out  1  one-cycle pulse on a fetch parity mismatch.

Function
REQ-017 Fetch: data_out SHALL equal mem[address] one cycle after address is sampled, if address < DEPTH; otherwise data_out SHALL hold its value and addr_error SHALL pulse.
REQ-018 Fetches SHALL proceed during a load session; a fetch of the word committed in the same cycle SHALL return the old content.
REQ-019 The loader FSM SHALL have the states IDLE, COLLECT and COMMIT; load_busy = (state != IDLE); load_ready = (state == COLLECT).
REQ-020 load_start in any state, with load_addr < DEPTH, SHALL set wr_ptr=load_addr, byte count=0 and clear load_error, then enter COLLECT; if load_addr >= DEPTH, it SHALL set load_error and go to IDLE.
REQ-021 load_start SHALL take priority over load_end and over a byte handshake in the same cycle; that byte SHALL be discarded.
REQ-022 COLLECT: each load_valid&&load_ready SHALL shift in one byte, MSB-first (the first byte is the opcode); the byte that completes DATA_WIDTH/8 bytes SHALL move the FSM to COMMIT.
REQ-023 COMMIT (exactly one cycle, load_ready=0): the FSM SHALL write the word to mem[wr_ptr]; if wr_ptr == DEPTH-1 it SHALL set load_error and go to IDLE without wrapping; otherwise it SHALL increment wr_ptr and go to COLLECT.
REQ-024 load_end in COLLECT with count 0 SHALL go to IDLE; with a partial word, the FSM SHALL discard the word, set load_error and go to IDLE; load_end in IDLE or COMMIT SHALL be ignored (COMMIT completes first).

Reset
REQ-025 On reset_s2 the block SHALL clear data_out, addr_error, parity_error, load_error, wr_ptr and byte count, force the FSM to IDLE and drive load_ready=0 and load_busy=0.
REQ-026 Memory contents SHALL be unaffected by reset and SHALL be zero at power-up; a reset mid-session SHALL abandon any partial word unwritten.

Configuration
REQ-027 With PROG_MEM_PARITY_EN defined, each word SHALL store an even-parity bit, written at COMMIT and checked at fetch; a mismatch SHALL pulse parity_error alongside the registered data_out.
REQ-028 Without PROG_MEM_PARITY_EN, no parity storage SHALL exist and parity_error SHALL be tied to 0.

Structure
REQ-029 The loader state enum and the default DATA_WIDTH/ADDR_WIDTH/DEPTH constants SHALL reside in the shared def package.
REQ-030 The byte assembler and FSM SHALL be a sub-module, prog_mem_loader, that outputs the write enable, address and word.

Verification
REQ-031 Reset asserted mid-fetch -> data_out=0, load_ready=0, load_busy=0, load_error=0 asynchronously.
REQ-032 load_start at 0x10, bytes 0A 10 05 01 02 03, load_end -> fetch 0x10 gives 0x0A1005, fetch 0x11 gives 0x010203, load_error=0.
REQ-033 DEPTH=27, fetch 0x1B after fetch 0x00 -> data_out holds mem[0x00], addr_error high for 1 cycle.
REQ-034 load_addr=DEPTH-1, six bytes -> first word written, load_error=1, FSM in IDLE, mem[0] unchanged.
REQ-035 load_start, bytes 0A 10, load_end -> load_error=1, target word unchanged; next load_start clears load_error.
REQ-036 With PROG_MEM_PARITY_EN, backdoor flip of bit 0 at 0x10, fetch 0x10 -> parity_error pulses 1 cycle.
